// File: rtl/tdm_demux_1to4.sv
// Four-slot TDM receive demultiplexer: tracks frame position from a sync marker,
// reassembles four-slot frames into a parallel word and counts framing errors.
module tdm_demux_1to4 #(
  parameter int WIDTH = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic               sync,
  input  logic [WIDTH-1:0]   din,
  output logic [4*WIDTH-1:0] out,
  output logic               out_valid,
  output logic [1:0]         slot,
  output logic               locked,
  output logic               sync_err,
  output logic [7:0]         err_count
);

  typedef enum logic {
    HUNT,
    LOCKED
  } state_t;

  state_t             state_reg, state_next;
  logic [1:0]         slot_reg, slot_next;
  logic [WIDTH-1:0]   sh_reg [3];
  logic [WIDTH-1:0]   sh_next [3];
  logic [4*WIDTH-1:0] out_reg, out_next;
  logic               out_valid_reg, out_valid_next;
  logic               sync_err_reg, sync_err_next;
  logic [7:0]         err_count_reg, err_count_next;
  logic               err_hit;

  always_comb begin
    state_next     = state_reg;
    slot_next      = slot_reg;
    sh_next        = sh_reg;
    out_next       = out_reg;
    out_valid_next = 1'b0;
    sync_err_next  = 1'b0;
    err_count_next = err_count_reg;
    err_hit        = 1'b0;

    if (enable) begin
      case (state_reg)
        HUNT: begin
          if (sync) begin
            sh_next[0] = din;
            slot_next  = 2'd1;
            state_next = LOCKED;
          end
        end
        LOCKED: begin
          if (sync) begin
            // A sync anywhere but slot 0 realigns: this sample becomes slot 0.
            err_hit    = (slot_reg != 2'd0);
            sh_next[0] = din;
            slot_next  = 2'd1;
          end else begin
            case (slot_reg)
              2'd0: begin
                err_hit    = 1'b1;
                slot_next  = 2'd0;
                state_next = HUNT;
              end
              2'd1: begin
                sh_next[1] = din;
                slot_next  = 2'd2;
              end
              2'd2: begin
                sh_next[2] = din;
                slot_next  = 2'd3;
              end
              default: begin
                out_next       = {din, sh_reg[2], sh_reg[1], sh_reg[0]};
                out_valid_next = 1'b1;
                slot_next      = 2'd0;
              end
            endcase
          end
        end
        default: state_next = HUNT;
      endcase
    end

    if (err_hit) begin
      sync_err_next = 1'b1;
      if (err_count_reg != 8'hFF) begin
        err_count_next = err_count_reg + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= HUNT;
      slot_reg      <= 2'd0;
      out_reg       <= '0;
      out_valid_reg <= 1'b0;
      sync_err_reg  <= 1'b0;
      err_count_reg <= 8'd0;
    end else begin
      state_reg     <= state_next;
      slot_reg      <= slot_next;
      out_reg       <= out_next;
      out_valid_reg <= out_valid_next;
      sync_err_reg  <= sync_err_next;
      err_count_reg <= err_count_next;
    end
  end

  for (genvar gi = 0; gi < 3; gi++) begin : g_shadow
    always_ff @(posedge clk) begin
      if (rst) begin
        sh_reg[gi] <= '0;
      end else begin
        sh_reg[gi] <= sh_next[gi];
      end
    end
  end

  assign out       = out_reg;
  assign out_valid = out_valid_reg;
  assign slot      = slot_reg;
  assign locked    = (state_reg == LOCKED);
  assign sync_err  = sync_err_reg;
  assign err_count = err_count_reg;

endmodule
